if_id_queue: RTL

Two-entry instruction queue between the fetch stage and decode. It captures each fetched `{pc, pc_plus4, instr}` bundle with a valid/ready handshake and presents it to decode in order. Decode can stall without dropping fetched instructions. A redirect flush discards everything in flight.

---
 rtl/if_id_queue.sv | 92 +++++++++
 1 files changed

// File: rtl/if_id_queue.sv
// Two-entry fetch-to-decode instruction queue with valid/ready handshakes on both sides.
// Optional combinational empty-queue bypass when IF_ID_QUEUE_BYPASS_EN is defined.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module if_id_queue #(
  parameter int DATA_WIDTH = `DATA_WIDTH,
  parameter int DEPTH      = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_pc,
  input  logic [DATA_WIDTH-1:0] in_pc_plus4,
  input  logic [31:0]           in_instr,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_pc,
  output logic [DATA_WIDTH-1:0] out_pc_plus4,
  output logic [31:0]           out_instr,
  output logic                  out_misaligned,
  output logic [1:0]            count
);

  localparam logic [1:0] FULL = 2'(DEPTH);

  logic [DATA_WIDTH-1:0] pc_mem    [2];
  logic [DATA_WIDTH-1:0] pc4_mem   [2];
  logic [31:0]           instr_mem [2];
  logic                  mis_mem   [2];

  logic [1:0] count_reg, count_next;
  logic       wr_ptr_reg, rd_ptr_reg;
  logic       push, pop, bypass, has_entry, in_misaligned;

  assign has_entry     = (count_reg != 2'd0);
  assign in_ready      = (count_reg != FULL);
  assign in_misaligned = (in_pc[1:0] != 2'b00);

`ifdef IF_ID_QUEUE_BYPASS_EN
  assign bypass = ~has_entry & in_valid & ~flush;
`else
  assign bypass = 1'b0;
`endif

  // A bypassed bundle that decode takes immediately never occupies a slot.
  assign push = in_valid & in_ready & ~flush & ~(bypass & out_ready);
  assign pop  = has_entry & out_ready & ~flush;

  assign count_next = count_reg + {1'b0, push} - {1'b0, pop};
  assign count      = count_reg;
  assign out_valid  = has_entry | bypass;

  always_comb begin
    out_pc         = pc_mem[rd_ptr_reg];
    out_pc_plus4   = pc4_mem[rd_ptr_reg];
    out_instr      = instr_mem[rd_ptr_reg];
    out_misaligned = has_entry & mis_mem[rd_ptr_reg];
    if (bypass) begin
      out_pc         = in_pc;
      out_pc_plus4   = in_pc_plus4;
      out_instr      = in_instr;
      out_misaligned = in_misaligned;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      count_reg  <= 2'd0;
      wr_ptr_reg <= 1'b0;
      rd_ptr_reg <= 1'b0;
    end else begin
      count_reg <= count_next;
      if (push) wr_ptr_reg <= ~wr_ptr_reg;
      if (pop)  rd_ptr_reg <= ~rd_ptr_reg;
    end
  end

  // Payload storage is never cleared; only the occupancy state decides validity.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr_reg]    <= in_pc;
      pc4_mem[wr_ptr_reg]   <= in_pc_plus4;
      instr_mem[wr_ptr_reg] <= in_instr;
      mis_mem[wr_ptr_reg]   <= in_misaligned;
    end
  end

endmodule
